// File: rtl/rdoq_cost_select.sv
// rdoq_cost_select
//   Rate-distortion cost selection behind the RDOQ distortion stage. Each
//   valid candidate carries a scaled distortion, a rate estimate, lambda and
//   its quantized level. The block forms J = D + ((lambda*rate) << RATE_SHIFT)
//   and keeps the cheapest candidate of each coefficient. On the last
//   candidate of a coefficient it reports the winner.
//
//   Pipeline: S1 rate term, S2 cost sum, S3 running-minimum select.
//   best_valid_out pulses three cycles after the last candidate is presented.
//
//   Build option: define RDOQ_COST_SAT_EN to saturate the S2 sum to all-ones
//   on carry-out; without it the sum wraps modulo 2^COST_WIDTH.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   data_valid_in     candidate present this cycle (no backpressure)
//   distortion_in     scaled distortion of the candidate
//   rate_in           estimated rate (unsigned, fractional bits)
//   lambda            Lagrange multiplier, sampled with each candidate
//   cand_level        quantized level of the candidate
//   cand_last         last candidate of the current coefficient
//   best_valid_out    one-cycle result pulse per coefficient
//   best_level_out    winning level (held until next pulse)
//   best_cost_out     winning cost (held until next pulse)
//   cand_count_out    candidates evaluated, saturating at MAX_CANDS
//   err_overflow      sticky: more than MAX_CANDS candidates in a coefficient
//
// Select FSM
//   state    | meaning
//   ST_FIRST | next valid candidate opens a new coefficient
//   ST_ACCUM | coefficient open, running best held in best_*_q
module rdoq_cost_select #(
   parameter int DIST_WIDTH      = 162,
   parameter int ABS_LEVEL_WIDTH = 32,
   parameter int RATE_WIDTH      = 32,
   parameter int LAMBDA_WIDTH    = 32,
   parameter int RATE_SHIFT      = 20,
   parameter int COST_WIDTH      = 164,
   parameter int MAX_CANDS       = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                data_valid_in,
   input  logic [DIST_WIDTH-1:0]               distortion_in,
   input  logic [RATE_WIDTH-1:0]               rate_in,
   input  logic [LAMBDA_WIDTH-1:0]             lambda,
   input  logic [ABS_LEVEL_WIDTH-1:0]          cand_level,
   input  logic                                cand_last,
   output logic                                best_valid_out,
   output logic [ABS_LEVEL_WIDTH-1:0]          best_level_out,
   output logic [COST_WIDTH-1:0]               best_cost_out,
   output logic [$clog2(MAX_CANDS+1)-1:0]      cand_count_out,
   output logic                                err_overflow
);

   localparam int CNT_W  = $clog2(MAX_CANDS + 1);
   localparam int PROD_W = LAMBDA_WIDTH + RATE_WIDTH;
   localparam int EXT_W  = (PROD_W + RATE_SHIFT > COST_WIDTH) ? PROD_W + RATE_SHIFT : COST_WIDTH;

   typedef enum logic {
      ST_FIRST = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // ---------------------------------------------------------------- S1
   logic [PROD_W-1:0]          prod_c;
   logic [EXT_W-1:0]           ext_c;
   logic [COST_WIDTH-1:0]      rterm_c;

   logic                       s1_valid;
   logic                       s1_last;
   logic [COST_WIDTH-1:0]      s1_rterm;
   logic [COST_WIDTH-1:0]      s1_dist;
   logic [ABS_LEVEL_WIDTH-1:0] s1_level;

   always_comb begin
      prod_c  = PROD_W'(lambda) * PROD_W'(rate_in);
      ext_c   = EXT_W'(prod_c) << RATE_SHIFT;
      rterm_c = ext_c[COST_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_rterm <= '0;
         s1_dist  <= '0;
         s1_level <= '0;
      end else begin
         s1_valid <= data_valid_in;
         if (data_valid_in) begin
            s1_last  <= cand_last;
            s1_rterm <= rterm_c;
            s1_dist  <= COST_WIDTH'(distortion_in);
            s1_level <= cand_level;
         end
      end
   end

   // ---------------------------------------------------------------- S2
   logic [COST_WIDTH-1:0]      cost_c;

`ifdef RDOQ_COST_SAT_EN
   logic [COST_WIDTH:0]        sum_c;

   always_comb begin
      sum_c  = {1'b0, s1_dist} + {1'b0, s1_rterm};
      cost_c = sum_c[COST_WIDTH] ? {COST_WIDTH{1'b1}} : sum_c[COST_WIDTH-1:0];
   end
`else
   always_comb begin
      cost_c = s1_dist + s1_rterm;
   end
`endif

   logic                       s2_valid;
   logic                       s2_last;
   logic [COST_WIDTH-1:0]      s2_cost;
   logic [ABS_LEVEL_WIDTH-1:0] s2_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_cost  <= '0;
         s2_level <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_last  <= s1_last;
            s2_cost  <= cost_c;
            s2_level <= s1_level;
         end
      end
   end

   // ---------------------------------------------------------------- S3
   state_t                     state_q;
   state_t                     state_d;
   logic [COST_WIDTH-1:0]      best_cost_q;
   logic [ABS_LEVEL_WIDTH-1:0] best_level_q;
   logic [CNT_W-1:0]           cnt_q;

   logic                       take_c;
   logic [CNT_W-1:0]           cnt_d;
   logic                       ovf_hit_c;
   logic                       pulse_c;
   logic [COST_WIDTH-1:0]      sel_cost_c;
   logic [ABS_LEVEL_WIDTH-1:0] sel_level_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FIRST;
      end else begin
         state_q <= state_d;
      end
   end

   // Strict less-than keeps the earlier candidate on equal cost.
   always_comb begin
      state_d   = state_q;
      take_c    = 1'b0;
      cnt_d     = cnt_q;
      ovf_hit_c = 1'b0;
      pulse_c   = 1'b0;
      if (s2_valid) begin
         if (state_q == ST_FIRST) begin
            take_c = 1'b1;
            cnt_d  = CNT_W'(1);
         end else begin
            take_c = (s2_cost < best_cost_q);
            if (cnt_q == CNT_W'(MAX_CANDS)) begin
               ovf_hit_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         if (s2_last) begin
            state_d = ST_FIRST;
            pulse_c = 1'b1;
         end else begin
            state_d = ST_ACCUM;
         end
      end
      sel_cost_c  = take_c ? s2_cost  : best_cost_q;
      sel_level_c = take_c ? s2_level : best_level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_cost_q    <= '0;
         best_level_q   <= '0;
         cnt_q          <= '0;
         best_valid_out <= 1'b0;
         best_level_out <= '0;
         best_cost_out  <= '0;
         cand_count_out <= '0;
         err_overflow   <= 1'b0;
      end else begin
         best_valid_out <= pulse_c;
         if (ovf_hit_c) begin
            err_overflow <= 1'b1;
         end
         if (s2_valid) begin
            best_cost_q  <= sel_cost_c;
            best_level_q <= sel_level_c;
            cnt_q        <= cnt_d;
         end
         if (pulse_c) begin
            best_level_out <= sel_level_c;
            best_cost_out  <= sel_cost_c;
            cand_count_out <= cnt_d;
         end
      end
   end

endmodule

// File: tb/tb_rdoq_cost_select.sv
module tb_rdoq_cost_select;

   localparam int DW   = 48;
   localparam int LW   = 8;
   localparam int RW   = 16;
   localparam int AW   = 16;
   localparam int RS   = 0;
   localparam int CW   = 48;
   localparam int MC   = 4;
   localparam int CNTW = $clog2(MC + 1);

   logic            clk;
   logic            rst_n;
   logic            data_valid_in;
   logic [DW-1:0]   distortion_in;
   logic [RW-1:0]   rate_in;
   logic [AW-1:0]   lambda;
   logic [LW-1:0]   cand_level;
   logic            cand_last;
   logic            best_valid_out;
   logic [LW-1:0]   best_level_out;
   logic [CW-1:0]   best_cost_out;
   logic [CNTW-1:0] cand_count_out;
   logic            err_overflow;

   rdoq_cost_select #(
      .DIST_WIDTH      (DW),
      .ABS_LEVEL_WIDTH (LW),
      .RATE_WIDTH      (RW),
      .LAMBDA_WIDTH    (AW),
      .RATE_SHIFT      (RS),
      .COST_WIDTH      (CW),
      .MAX_CANDS       (MC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_valid_in  (data_valid_in),
      .distortion_in  (distortion_in),
      .rate_in        (rate_in),
      .lambda         (lambda),
      .cand_level     (cand_level),
      .cand_last      (cand_last),
      .best_valid_out (best_valid_out),
      .best_level_out (best_level_out),
      .best_cost_out  (best_cost_out),
      .cand_count_out (cand_count_out),
      .err_overflow   (err_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference cost straight from the definition J = D + ((lambda*rate) << RS).
   function automatic longint unsigned model_cost(input longint unsigned d,
                                                  input longint unsigned lam,
                                                  input longint unsigned r);
      longint unsigned s;
      longint unsigned lim;
      lim = 64'd1 << CW;
      s   = d + ((lam * r) << RS);
`ifdef RDOQ_COST_SAT_EN
      if (s >= lim) s = lim - 1;
`else
      s = s % lim;
`endif
      return s;
   endfunction

   task automatic drive(input logic [AW-1:0] lam, input logic [LW-1:0] lvl,
                        input logic [DW-1:0] d, input logic [RW-1:0] r, input logic last);
      @(negedge clk);
      data_valid_in = 1'b1;
      lambda        = lam;
      cand_level    = lvl;
      distortion_in = d;
      rate_in       = r;
      cand_last     = last;
   endtask

   // Idle cycle with junk on the data lines; none of it may be consumed.
   task automatic idle();
      @(negedge clk);
      data_valid_in = 1'b0;
      lambda        = AW'($urandom);
      cand_level    = LW'($urandom);
      distortion_in = DW'($urandom);
      rate_in       = RW'($urandom);
      cand_last     = 1'($urandom);
   endtask

   // Waits (bounded) for the result pulse; lat counts posedges from the last drive.
   task automatic wait_pulse(output int lat);
      lat = 99;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         data_valid_in = 1'b0;
         if (best_valid_out) begin
            lat = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic [AW-1:0]   lam;
      logic [LW-1:0]   lvl;
      logic [DW-1:0]   d;
      logic [RW-1:0]   r;
      logic            last;
      logic [LW-1:0]   e_lvl;
      logic [CW-1:0]   e_cost;
      logic [CNTW-1:0] e_cnt;
   } vec_t;

   localparam int NT = 7;
   vec_t tbl[NT];

   typedef struct {
      logic [LW-1:0]   lvl;
      longint unsigned cost;
      int              cnt;
      bit              ovf;
   } res_t;

   res_t exp_q[$];
   bit   mon_en = 1'b0;

   always @(posedge clk) begin
      #1;
      if (mon_en && best_valid_out) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd_unexpected_pulse: got pulse expected none");
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("rnd_level", 64'(best_level_out), 64'(e.lvl));
            chk("rnd_cost",  64'(best_cost_out),  e.cost);
            chk("rnd_count", 64'(cand_count_out), 64'(e.cnt));
            chk("rnd_ovf",   64'(err_overflow),   64'(e.ovf));
         end
      end
   end

   initial begin
      int              lat;
      bit              exp_pulse;
      int              idx;
      logic [63:0]     tmp64;
      logic [DW-1:0]   dv;
      bit              ovf_model;
      longint unsigned costs[8];
      logic [LW-1:0]   lvls[8];
      logic [AW-1:0]   lams[8];
      logic [DW-1:0]   dists[8];
      logic [RW-1:0]   rates[8];

      //            lam  lvl  D    R   last  e_lvl e_cost e_cnt
      tbl[0] = '{4,   2,  100, 5,  1'b0, 0, 0,  0};
      tbl[1] = '{4,   1,  50,  10, 1'b0, 0, 0,  0};
      tbl[2] = '{4,   0,  200, 0,  1'b1, 1, 90, 3};
      tbl[3] = '{4,   2,  40,  5,  1'b0, 0, 0,  0};
      tbl[4] = '{4,   1,  52,  2,  1'b1, 2, 60, 2};
      tbl[5] = '{1,   3,  9,   1,  1'b1, 3, 10, 1};
      tbl[6] = '{1,   5,  1,   0,  1'b1, 5, 1,  1};

      rst_n         = 1'b0;
      data_valid_in = 1'b0;
      distortion_in = '0;
      rate_in       = '0;
      lambda        = '0;
      cand_level    = '0;
      cand_last     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(best_valid_out), 0);
      chk("rst_level", 64'(best_level_out), 0);
      chk("rst_cost",  64'(best_cost_out),  0);
      chk("rst_count", 64'(cand_count_out), 0);
      chk("rst_ovf",   64'(err_overflow),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table streamed without gaps; result of entry t lands on posedge t+2.
      for (int t = 0; t < NT + 3; t++) begin
         if (t < NT) drive(tbl[t].lam, tbl[t].lvl, tbl[t].d, tbl[t].r, tbl[t].last);
         else        idle();
         @(posedge clk);
         #1;
         idx       = t - 2;
         exp_pulse = (idx >= 0 && idx < NT) ? tbl[idx].last : 1'b0;
         chk("tbl_valid", 64'(best_valid_out), 64'(exp_pulse));
         if (exp_pulse) begin
            chk("tbl_level", 64'(best_level_out), 64'(tbl[idx].e_lvl));
            chk("tbl_cost",  64'(best_cost_out),  64'(tbl[idx].e_cost));
            chk("tbl_count", 64'(cand_count_out), 64'(tbl[idx].e_cnt));
         end
      end
      chk("tbl_hold_level", 64'(best_level_out), 5);
      chk("tbl_ovf_clear",  64'(err_overflow),   0);

      // Overflow: five candidates, minimum on the fifth.
      drive(1, 10, 50, 0, 1'b0);
      drive(1, 11, 40, 0, 1'b0);
      drive(1, 12, 30, 0, 1'b0);
      drive(1, 13, 60, 0, 1'b0);
      drive(1, 14, 20, 0, 1'b1);
      wait_pulse(lat);
      chk("ovf_latency", 64'(lat), 3);
      chk("ovf_level",   64'(best_level_out), 14);
      chk("ovf_cost",    64'(best_cost_out),  20);
      chk("ovf_count",   64'(cand_count_out), 4);
      chk("ovf_flag",    64'(err_overflow),   1);
      drive(2, 9, 3, 1, 1'b1);
      wait_pulse(lat);
      chk("ovf_sticky",  64'(err_overflow),   1);
      chk("ovf_next_cost",  64'(best_cost_out),  5);
      chk("ovf_next_count", 64'(cand_count_out), 1);

      // Carry out of the cost sum.
      dv = '1;
      drive(1, 6, dv, 1, 1'b1);
      wait_pulse(lat);
      chk("sat_latency", 64'(lat), 3);
      chk("sat_level",   64'(best_level_out), 6);
`ifdef RDOQ_COST_SAT_EN
      chk("sat_cost",    64'(best_cost_out), {16'd0, {CW{1'b1}}});
`else
      chk("sat_cost",    64'(best_cost_out), 0);
`endif

      // Reset mid-coefficient, then a fresh single candidate.
      drive(3, 1, 10, 0, 1'b0);
      drive(3, 2, 20, 0, 1'b0);
      @(negedge clk);
      rst_n         = 1'b0;
      data_valid_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_valid", 64'(best_valid_out), 0);
      chk("mid_rst_cost",  64'(best_cost_out),  0);
      chk("mid_rst_ovf",   64'(err_overflow),   0);
      rst_n = 1'b1;
      drive(3, 7, 5, 0, 1'b1);
      wait_pulse(lat);
      chk("mid_rst_latency", 64'(lat), 3);
      chk("mid_rst_level",   64'(best_level_out), 7);
      chk("mid_rst_cost2",   64'(best_cost_out),  5);
      chk("mid_rst_count",   64'(cand_count_out), 1);
      repeat (4) idle();

      // Randomised coefficients against the reference model.
      ovf_model = 1'b0;
      mon_en    = 1'b1;
      for (int c = 0; c < 80; c++) begin
         int n;
         int best_i;
         res_t e;
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
               1: begin tmp64 = {$urandom(), $urandom()}; dists[k] = tmp64[DW-1:0]; end
               2: dists[k] = {DW{1'b1}} - DW'($urandom_range(0, 40));
               default: dists[k] = DW'($urandom_range(0, 300));
            endcase
            lams[k]  = AW'($urandom_range(0, 15));
            rates[k] = RW'($urandom_range(0, 20));
            lvls[k]  = LW'($urandom_range(0, 255));
            costs[k] = model_cost(64'(dists[k]), 64'(lams[k]), 64'(rates[k]));
         end
         best_i = 0;
         for (int k = 1; k < n; k++) if (costs[k] < costs[best_i]) best_i = k;
         if (n > MC) ovf_model = 1'b1;
         e.lvl  = lvls[best_i];
         e.cost = costs[best_i];
         e.cnt  = (n > MC) ? MC : n;
         e.ovf  = ovf_model;
         exp_q.push_back(e);
         for (int k = 0; k < n; k++) begin
            drive(lams[k], lvls[k], dists[k], rates[k], (k == n - 1));
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 2)) idle();
            end
         end
      end
      repeat (6) idle();
      chk("rnd_drain", 64'(exp_q.size()), 0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end of test expected finish");
      $fatal(1);
   end

endmodule
